// File: rtl/std_sdivmod_pipe_if.sv
// Handshake bundle for std_sdivmod_pipe: go/left/right from the controller,
// quotient/remainder/done back from the divider.
interface std_sdivmod_pipe_if #(
    parameter int width = 32
);
    logic             go;
    logic [width-1:0] left;
    logic [width-1:0] right;
    logic [width-1:0] out_quotient;
    logic [width-1:0] out_remainder;
    logic             done;

    modport master (
        output go,
        output left,
        output right,
        input  out_quotient,
        input  out_remainder,
        input  done
    );

    modport slave (
        input  go,
        input  left,
        input  right,
        output out_quotient,
        output out_remainder,
        output done
    );
endinterface

// File: rtl/std_sdivmod_pipe.sv
// std_sdivmod_pipe: multi-cycle signed divider returning the C-style truncated
// quotient and remainder (remainder takes the dividend's sign).
// Operands are reduced to width-bit magnitudes, divided by a restoring
// shift-subtract core (one bit per cycle), then sign-corrected.
// Optional feature macro: SDIVMOD_EARLY_OUT_EN -- when defined, a zero dividend
// or zero divisor skips the iteration phase and finishes in two cycles.
module std_sdivmod_pipe #(
    parameter int width = 32
) (
    input  logic              clk,
    input  logic              reset,
    std_sdivmod_pipe_if.slave bus
);
    localparam int cnt_w = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [cnt_w-1:0] cnt_r;
    logic [width-1:0] abs_l_r;   // |left|, kept intact for the divide-by-zero remainder
    logic [width-1:0] abs_r_r;   // |right|
    logic [width-1:0] dvd_r;     // dividend magnitude, shifted out MSB first
    logic [width:0]   rem_r;     // partial remainder
    logic [width-1:0] quo_r;     // quotient magnitude, shifted in LSB first
    logic             sign_l_r;
    logic             sign_r_r;
    logic             div0_r;
    logic [width-1:0] q_out_r;
    logic [width-1:0] r_out_r;
    logic             done_r;

    logic [width+1:0] trial_s;
    logic             trial_ok_s;
    logic [width-1:0] q_fix_s;
    logic [width-1:0] r_fix_s;

    // Two's complement negation; MIN maps to itself, which gives the MIN/-1 wrap.
    function automatic logic [width-1:0] neg_f(input logic [width-1:0] v);
        return (~v) + width'(1);
    endfunction

    // Unsigned magnitude of a signed operand; |MIN| = 2^(width-1) fits exactly.
    function automatic logic [width-1:0] mag_f(input logic [width-1:0] v);
        return v[width-1] ? neg_f(v) : v;
    endfunction

    // Restoring step: the trial subtraction is one bit wider than the shifted
    // remainder so its MSB is a clean borrow/sign indicator.
    always_comb begin
        trial_s    = {rem_r, dvd_r[width-1]} - {2'b00, abs_r_r};
        trial_ok_s = ~trial_s[width+1];
    end

    // Sign correction; a zero divisor keeps the all-ones quotient and hands back
    // the original dividend as the remainder.
    always_comb begin
        q_fix_s = quo_r;
        r_fix_s = rem_r[width-1:0];
        if (div0_r) begin
            q_fix_s = {width{1'b1}};
            r_fix_s = sign_l_r ? neg_f(abs_l_r) : abs_l_r;
        end else begin
            q_fix_s = (sign_l_r ^ sign_r_r) ? neg_f(quo_r) : quo_r;
            r_fix_s = sign_l_r ? neg_f(rem_r[width-1:0]) : rem_r[width-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs; reset wins over go.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {cnt_w{1'b0}};
            abs_l_r  <= {width{1'b0}};
            abs_r_r  <= {width{1'b0}};
            dvd_r    <= {width{1'b0}};
            rem_r    <= {(width+1){1'b0}};
            quo_r    <= {width{1'b0}};
            sign_l_r <= 1'b0;
            sign_r_r <= 1'b0;
            div0_r   <= 1'b0;
            q_out_r  <= {width{1'b0}};
            r_out_r  <= {width{1'b0}};
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.go) begin
                        abs_l_r  <= mag_f(bus.left);
                        abs_r_r  <= mag_f(bus.right);
                        dvd_r    <= mag_f(bus.left);
                        sign_l_r <= bus.left[width-1];
                        sign_r_r <= bus.right[width-1];
                        div0_r   <= (bus.right == {width{1'b0}});
                        rem_r    <= {(width+1){1'b0}};
                        quo_r    <= {width{1'b0}};
                        cnt_r    <= cnt_w'(width);
`ifdef SDIVMOD_EARLY_OUT_EN
                        if ((bus.left == {width{1'b0}}) || (bus.right == {width{1'b0}})) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= RUN;
                        end
`else
                        state_r <= RUN;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!bus.go) begin
                        state_r <= IDLE;
                    end else begin
                        if (trial_ok_s) begin
                            rem_r <= trial_s[width:0];
                            quo_r <= {quo_r[width-2:0], 1'b1};
                        end else begin
                            rem_r <= {rem_r[width-1:0], dvd_r[width-1]};
                            quo_r <= {quo_r[width-2:0], 1'b0};
                        end
                        dvd_r <= {dvd_r[width-2:0], 1'b0};
                        cnt_r <= cnt_r - cnt_w'(1);
                        if (cnt_r == cnt_w'(1)) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                FIX: begin
                    if (!bus.go) begin
                        state_r <= IDLE;
                    end else begin
                        q_out_r <= q_fix_s;
                        r_out_r <= r_fix_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_quotient  = q_out_r;
    assign bus.out_remainder = r_out_r;
    assign bus.done          = done_r;
endmodule
